instr_encode: RTL
=================

# instr_encode

Field-to-word RISC-V RV32I instruction encoder with a valid/ready stream interface: the inverse of `instr_decode`. Accepts a format code plus opcode/register/funct/immediate fields, packs them into a 32-bit instruction word, range-checks the immediate, and presents the word with a running program address on a registered output stage. Used by the program-loader and self-test paths to generate instruction memory images and to feed round-trip stimulus into `instr_decode`.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h0000_0000: address of the first emitted word and the value `out_addr` reloads to.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear: reload address, clear error count, drop output.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `fmt`  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- `opcode`  in  7  placed in bits [6:0] unchanged.
- `rd`, `rs1`, `rs2`  in  5 each  register indices.
- `funct3`  in  3  bits [14:12] for R/I/S/B.
- `funct7`  in  7  bits [31:25] for R only.
- `imm`  in  32  signed byte-offset or upper immediate.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32  encoded instruction.
- `out_addr`  out  32  address of the word on `out_instr`.
- `out_err`  out  1  the presented word failed its range check.
- `err_cnt`  out  8  saturating count of errored words transferred.

## Operation

- Packing per `fmt`:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Fields not used by a format are ignored.
- Range checks. Error if any of the following holds:
  - I/S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094], or imm[0]=1.
  - U: imm[11:0]≠0.
  - J: imm not in [-1048576, 1048574], or imm[0]=1.
  - fmt is 6 or 7.
  - R: never errors.
- On error the stage holds `out_instr`=32'h0000_0013 (NOP, addi x0,x0,0) with `out_err`=1. The address still advances.
- Single output register stage. `in_ready` = !clr && (!out_valid || out_ready).
- Accept (in_valid && in_ready): load encoded word and error bit, set `out_valid`=1 next cycle.
- Transfer (out_valid && out_ready):
  - `out_addr` += 4, wrapping modulo 2^32.
  - If `out_err`=1, `err_cnt` += 1, saturating at 255.
  - `out_valid` clears unless a new accept occurs in the same cycle.
- Transfer and accept in the same cycle: the new word is loaded and `out_valid` stays 1, giving full throughput.
- Backpressure: while out_valid && !out_ready, `out_instr`/`out_addr`/`out_err` are held stable.
- `clr`:
  - Priority over all other activity. No accept, no transfer counted.
  - Next cycle: `out_valid`=0, `out_addr`=BASE_ADDR, `err_cnt`=0.

## Timing

- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `out_err`=0, `err_cnt`=0. `in_ready`=1 after reset is released.
- Reset asserted mid-transfer discards the held word immediately (asynchronous).
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 word/cycle.
- `in_ready` is combinational from `out_valid`, `out_ready`, `clr`. No combinational path from `in_*` data to outputs.

## Test plan

- add x1,x2,x3: fmt=0, op=0x33, rd=1, rs1=2, rs2=3, f3=0, f7=0.
  -> 0x003100B3, out_addr=BASE_ADDR, out_err=0, one cycle after accept.
- Back-to-back stream with out_ready=1:
  - addi x5,x6,0x12 (fmt=1, op=0x13) -> 0x01230293.
  - sw x9,0(x8) (fmt=2, op=0x23, f3=2) -> 0x00942023.
  - lui x10,0x12345000 (fmt=4, op=0x37) -> 0x12345537.
  - Addresses BASE, +4, +8. No bubbles.
- beq x1,x2,+8 (fmt=3, op=0x63) -> 0x00208463. jal x1,+2048 (fmt=5, op=0x6F) -> 0x001000EF.
- Errors:
  - B with imm=3 -> 0x00000013, out_err=1.
  - I with imm=2048 -> same.
  - fmt=7 -> same.
  - err_cnt=3 after the three transfers; address advances each time.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 throughout; outputs stable.
  - On release, each word appears exactly once, in order.
- clr and reset:
  - Assert clr together with in_valid -> no accept; next cycle out_valid=0, out_addr=BASE_ADDR, err_cnt=0.
  - Assert rst asynchronously mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/instr_encode.sv
// RV32I field-to-word instruction encoder with a single registered output
// stage, a running program address and a saturating count of errored words.
module instr_encode #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        fits_12;
  logic        fits_13;
  logic        fits_21;
  logic [31:0] enc_word;
  logic        enc_err;

  logic        accept;
  logic        xfer;

  logic        valid_q,   valid_d;
  logic [31:0] instr_q,   instr_d;
  logic [31:0] addr_q,    addr_d;
  logic        err_q,     err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // An immediate fits N signed bits when every bit above N-1 equals the sign.
  assign fits_12 = (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
  assign fits_13 = (imm[31:12] == 20'h00000)  || (imm[31:12] == 20'hFFFFF);
  assign fits_21 = (imm[31:20] == 12'h000)    || (imm[31:20] == 12'hFFF);

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !fits_12;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !fits_12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !fits_13 || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !fits_21 || imm[0];
      end
      default: begin
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready = !clr && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = !clr && valid_q && out_ready;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      // Word register is left as-is; only the valid flag drops.
      valid_d   = 1'b0;
      addr_d    = BASE_ADDR;
      err_cnt_d = 8'h00;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
        addr_d  = addr_q + 32'd4;
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      if (accept) begin
        valid_d = 1'b1;
        instr_d = enc_err ? NOP : enc_word;
        err_d   = enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;
  assign err_cnt   = err_cnt_q;

endmodule
